// File: rtl/sram_mem_responder.sv
// Serves 32-bit MEM-stage word requests from a 16-bit asynchronous SRAM.
// Each word is two half-word accesses (low half first), and each half is
// held for WAIT_CYCLES clocks. ready stays low until the access completes.
module sram_mem_responder #(
    parameter int unsigned ADDR_OFFSET = 1024,
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wr_data,
    output logic [31:0]        rd_data,
    output logic               ready,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N
);

    localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               is_write_q, is_write_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rd_data_q, rd_data_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;

    logic [31:0]        offs;
    logic [SRAM_AW-2:0] word_addr;
    logic               unused_bits;
    logic               dq_oe;
    logic [15:0]        dq_out;

    // Word index relative to the SRAM base; wraps silently, no range check.
    assign offs        = address - ADDR_OFFSET;
    assign word_addr   = offs[SRAM_AW:2];
    assign unused_bits = ^{offs[31:SRAM_AW+1], offs[1:0]};

    assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;
    assign SRAM_ADDR = sram_addr_q;
    assign rd_data   = rd_data_q;

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            is_write_q  <= 1'b0;
            wdata_q     <= '0;
            rd_data_q   <= '0;
            sram_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_write_q  <= is_write_d;
            wdata_q     <= wdata_d;
            rd_data_q   <= rd_data_d;
            sram_addr_q <= sram_addr_d;
        end
    end

    // Next-state logic and SRAM strobes, decoded from the current state so
    // that an asynchronous reset releases WE_N without waiting for a clock.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_write_d  = is_write_q;
        wdata_d     = wdata_q;
        rd_data_d   = rd_data_q;
        sram_addr_d = sram_addr_q;
        ready       = 1'b0;
        SRAM_WE_N   = 1'b1;
        SRAM_OE_N   = 1'b1;
        dq_oe       = 1'b0;
        dq_out      = wdata_q[15:0];

        unique case (state_q)
            StIdle: begin
                ready = ~(rd_en | wr_en);
                if (rd_en | wr_en) begin
                    // Write takes priority when both commands are set.
                    is_write_d  = wr_en;
                    wdata_d     = wr_data;
                    sram_addr_d = {word_addr, 1'b0};
                    cnt_d       = '0;
                    state_d     = StLo;
                end
            end
            StLo, StHi: begin
                SRAM_WE_N = ~is_write_q;
                SRAM_OE_N = is_write_q;
                dq_oe     = is_write_q;
                dq_out    = (state_q == StHi) ? wdata_q[31:16] : wdata_q[15:0];
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (!is_write_q) begin
                        if (state_q == StLo) rd_data_d[15:0] = SRAM_DQ;
                        else                 rd_data_d[31:16] = SRAM_DQ;
                    end
                    if (state_q == StLo) begin
                        state_d        = StHi;
                        sram_addr_d[0] = 1'b1;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                ready   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_sram_mem_responder.sv
// Bench for sram_mem_responder: two instances (WAIT_CYCLES 2 and 1), each
// with a behavioural async SRAM, checked against a word-level memory model.
module tb_sram_mem_responder;

    localparam int unsigned AW = 18;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: WAIT_CYCLES = 2
    logic          rd_en, wr_en;
    logic [31:0]   address, wr_data, rd_data;
    logic          ready, we_n, oe_n;
    wire  [15:0]   sram_dq;
    logic [AW-1:0] sram_addr;
    logic [15:0]   mem0 [0:(1<<AW)-1];

    // Instance 1: WAIT_CYCLES = 1
    logic          rd_en1, wr_en1;
    logic [31:0]   address1, wr_data1, rd_data1;
    logic          ready1, we_n1, oe_n1;
    wire  [15:0]   sram_dq1;
    logic [AW-1:0] sram_addr1;
    logic [15:0]   mem1 [0:(1<<AW)-1];

    sram_mem_responder #(.ADDR_OFFSET(1024), .SRAM_AW(AW), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .wr_data(wr_data), .rd_data(rd_data), .ready(ready), .SRAM_DQ(sram_dq),
        .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n)
    );

    sram_mem_responder #(.ADDR_OFFSET(1024), .SRAM_AW(AW), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .rd_en(rd_en1), .wr_en(wr_en1), .address(address1),
        .wr_data(wr_data1), .rd_data(rd_data1), .ready(ready1), .SRAM_DQ(sram_dq1),
        .SRAM_ADDR(sram_addr1), .SRAM_WE_N(we_n1), .SRAM_OE_N(oe_n1)
    );

    // Behavioural SRAMs: drive on read, capture while WE_N is low.
    assign sram_dq  = (!oe_n && we_n) ? mem0[sram_addr] : 16'bz;
    assign sram_dq1 = (!oe_n1 && we_n1) ? mem1[sram_addr1] : 16'bz;
    always @(posedge clk) if (!we_n) mem0[sram_addr] <= sram_dq;
    always @(posedge clk) if (!we_n1) mem1[sram_addr1] <= sram_dq1;

    // Muxed view of whichever instance the current sequence targets.
    logic          sel = 1'b0;
    wire           c_ready = sel ? ready1 : ready;
    wire           c_we_n  = sel ? we_n1 : we_n;
    wire           c_oe_n  = sel ? oe_n1 : oe_n;
    wire  [31:0]   c_rd    = sel ? rd_data1 : rd_data;
    wire  [AW-1:0] c_addr  = sel ? sram_addr1 : sram_addr;

    int passed = 0;
    int total  = 0;

    typedef struct {
        int            low;
        int            oe_low;
        int            we_low;
        logic [31:0]   rd;
        logic [AW-1:0] a_first;
        logic [AW-1:0] a_last;
        bit            done;
    } res_t;

    typedef struct {
        logic          r;
        logic          w;
        logic [31:0]   a;
        logic [31:0]   d;
        logic [31:0]   exp_rd;
        logic [AW-1:0] exp_a0;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d);
        if (sel) begin
            rd_en1 = r; wr_en1 = w; address1 = a; wr_data1 = d;
        end else begin
            rd_en = r; wr_en = w; address = a; wr_data = d;
        end
    endtask

    // One request: counts ready-low cycles and strobe cycles, records the
    // SRAM addresses used and rd_data in the completing cycle.
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input bit drop, output res_t res);
        bit seen = 0;
        res.low = 0; res.oe_low = 0; res.we_low = 0; res.rd = '0;
        res.a_first = '0; res.a_last = '0; res.done = 0;
        @(posedge clk); #1;
        drive(r, w, a, d);
        for (int i = 0; i < 20 && !res.done; i++) begin
            @(negedge clk);
            if (c_ready) begin
                res.done = 1;
                res.rd   = c_rd;
            end else begin
                res.low++;
                if (!c_oe_n) res.oe_low++;
                if (!c_we_n) res.we_low++;
                if (!c_oe_n || !c_we_n) begin
                    if (!seen) res.a_first = c_addr;
                    res.a_last = c_addr;
                    seen = 1;
                end
                // Request vanishes and address moves once the access is under way.
                if (drop && res.low == 2) drive(1'b0, 1'b0, a + 32'h100, ~d);
            end
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0);
    endtask

    vec_t        vecs [7];
    res_t        res;
    logic [31:0] ref_mem [16];
    logic [31:0] exp_rd;
    logic [31:0] a, d;
    int          k;
    bit          is_wr;

    initial begin
        rd_en = 0; wr_en = 0; address = '0; wr_data = '0;
        rd_en1 = 0; wr_en1 = 0; address1 = '0; wr_data1 = '0;

        vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0,        18'd0};
        vecs[1] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF, 18'd0};
        vecs[2] = '{1'b0, 1'b1, 32'd1028, 32'h12345678, 32'hDEADBEEF, 18'd2};
        vecs[3] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF, 18'd0};
        vecs[4] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'h12345678, 18'd2};
        vecs[5] = '{1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, 32'h12345678, 18'd4};
        vecs[6] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'hA5A55A5A, 18'd4};

        // Reset state
        #12;
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_we_n", {31'b0, we_n}, 32'd1);
        check("rst_oe_n", {31'b0, oe_n}, 32'd1);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_sram_addr", {14'b0, sram_addr}, 32'h0);
        @(negedge clk); rst = 1'b1;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            access(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, 1'b0, res);
            check($sformatf("v%0d_done", i), {31'b0, res.done}, 32'd1);
            check($sformatf("v%0d_ready_low", i), res.low, 32'd5);
            check($sformatf("v%0d_rd_data", i), res.rd, vecs[i].exp_rd);
            check($sformatf("v%0d_addr_lo", i), {14'b0, res.a_first}, {14'b0, vecs[i].exp_a0});
            check($sformatf("v%0d_addr_hi", i), {14'b0, res.a_last},
                  {14'b0, vecs[i].exp_a0} + 32'd1);
            if (vecs[i].w) begin
                check($sformatf("v%0d_we_cycles", i), res.we_low, 32'd4);
                check($sformatf("v%0d_oe_cycles", i), res.oe_low, 32'd0);
                check($sformatf("v%0d_sram_lo", i), {16'b0, mem0[vecs[i].exp_a0]},
                      {16'b0, vecs[i].d[15:0]});
                check($sformatf("v%0d_sram_hi", i), {16'b0, mem0[vecs[i].exp_a0 + 1'b1]},
                      {16'b0, vecs[i].d[31:16]});
            end else begin
                check($sformatf("v%0d_oe_cycles", i), res.oe_low, 32'd4);
                check($sformatf("v%0d_we_cycles", i), res.we_low, 32'd0);
            end
        end

        // Randomized traffic over 16 words, sometimes through a wrapped alias
        exp_rd = 32'hA5A55A5A;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            access(1'b0, 1'b1, 32'd1024 + 32'(i) * 4, ref_mem[i], 1'b0, res);
            check("init_rd_kept", res.rd, exp_rd);
        end
        for (int i = 0; i < 40; i++) begin
            k     = int'($urandom_range(15, 0));
            is_wr = ($urandom_range(1, 0) == 1);
            a     = 32'd1024 + 32'(k) * 4;
            if ($urandom_range(3, 0) == 0) a = a + (32'd1 << (AW + 1));
            d     = $urandom;
            access(~is_wr, is_wr, a, d, 1'b0, res);
            if (is_wr) ref_mem[k] = d;
            else       exp_rd = ref_mem[k];
            check($sformatf("rnd%0d_ready_low", i), res.low, 32'd5);
            check($sformatf("rnd%0d_rd_data", i), res.rd, exp_rd);
            check($sformatf("rnd%0d_addr_lo", i), {14'b0, res.a_first}, 32'(k) * 2);
        end

        // WAIT_CYCLES=1 instance, request dropped and address moved mid-access
        sel = 1'b1;
        access(1'b0, 1'b1, 32'd1036, 32'hCAFEF00D, 1'b1, res);
        check("w1_ready_low", res.low, 32'd3);
        check("w1_we_cycles", res.we_low, 32'd2);
        check("w1_addr_lo", {14'b0, res.a_first}, 32'd6);
        check("w1_addr_hi", {14'b0, res.a_last}, 32'd7);
        check("w1_sram_lo", {16'b0, mem1[6]}, 32'h0000F00D);
        check("w1_sram_hi", {16'b0, mem1[7]}, 32'h0000CAFE);
        access(1'b1, 1'b0, 32'd1036, 32'h0, 1'b0, res);
        check("w1_read_ready_low", res.low, 32'd3);
        check("w1_read_oe_cycles", res.oe_low, 32'd2);
        check("w1_read_data", res.rd, 32'hCAFEF00D);
        sel = 1'b0;

        // Asynchronous reset in the middle of a write
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 32'd1024 + 32'd80, 32'h0BADF00D);
        repeat (2) @(negedge clk);
        check("midwr_we_active", {31'b0, we_n}, 32'd0);
        #1 rst = 1'b0;
        #1;
        check("midwr_we_n", {31'b0, we_n}, 32'd1);
        check("midwr_oe_n", {31'b0, oe_n}, 32'd1);
        check("midwr_rd_data", rd_data, 32'h0);
        drive(1'b0, 1'b0, '0, '0);
        #1;
        check("midwr_ready", {31'b0, ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_we_n%0d", i), {31'b0, we_n}, 32'd1);
            check($sformatf("post_rst_ready%0d", i), {31'b0, ready}, 32'd1);
        end
        access(1'b1, 1'b0, 32'd1024 + 32'd12, 32'h0, 1'b0, res);
        check("post_rst_read", res.rd, ref_mem[3]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
